bram_sweep: RTL and testbench

BRAM_SWEEP -- requirements
Module: bram_sweep

---
 rtl/bram_sweep_pkg.sv | 13 +
 rtl/bram_sp.sv | 30 +++
 rtl/bram_sweep.sv | 143 ++++++++++++++
 tb/tb_bram_sweep.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_sweep_pkg.sv
// Shared state encoding and sweep-mode constants for the BRAM sweep engine.
package bram_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic MODE_READ = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/bram_sp.sv
// Single-port synchronous RAM, read-before-write on a shared address.
// Latency: rdata valid one cycle after addr is presented.
// Backpressure: none; one access accepted every cycle.
module bram_sp #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset: contents must survive a reset of the surrounding engine.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bram_sweep.sv
// Sweep engine: fills or scans a RAM window, with host access while idle.
// Latency: one access per RUN cycle; read beats appear one cycle after issue.
// Backpressure: none; start and host writes are dropped while busy.
module bram_sweep
    import bram_sweep_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] seed,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              done_q, done_d;
    logic              rd_vld_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              host_rd_q;
    logic [DATA_W-1:0] host_hold_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    bram_sp #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        val_d     = val_q;
        done_d    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
        case (state_q)
            ST_IDLE: begin
                ram_we = host_we;
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        mode_d  = mode;
                        addr_d  = base_addr;
                        cnt_d   = len;
                        val_d   = seed;
                    end
                end
            end
            ST_RUN: begin
                ram_addr  = addr_q;
                ram_wdata = val_q;
                ram_we    = (mode_q == MODE_FILL);
                addr_d    = addr_q + ADDR_W'(1);
                val_d     = val_q + DATA_W'(1);
                cnt_d     = cnt_q - (ADDR_W+1)'(1);
                if (cnt_q == (ADDR_W+1)'(1)) begin
                    // Reads need one extra cycle for the last word to come back.
                    if (mode_q == MODE_FILL) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_READ;
            addr_q      <= '0;
            cnt_q       <= '0;
            val_q       <= '0;
            done_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_addr_q   <= '0;
            host_rd_q   <= 1'b0;
            host_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            val_q       <= val_d;
            done_q      <= done_d;
            rd_vld_q    <= (state_q == ST_RUN) && (mode_q == MODE_READ);
            if (state_q == ST_RUN) begin
                rd_addr_q <= addr_q;
            end
            host_rd_q   <= (state_q == ST_IDLE);
            host_hold_q <= host_rdata;
        end
    end

    // RAM output is only meaningful for the host after an idle-cycle access.
    assign host_rdata = (state_q == ST_IDLE && host_rd_q) ? ram_rdata : host_hold_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign rd_valid   = rd_vld_q;
    assign rd_addr    = rd_addr_q;
    assign rd_data    = rd_vld_q ? ram_rdata : '0;

endmodule

// File: tb/tb_bram_sweep.sv
// Directed bench for bram_sweep with a read-beat scoreboard and a memory model.
module tb_bram_sweep;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [4:0] base_addr;
    logic [5:0] len;
    logic [3:0] seed;
    logic       host_we;
    logic [4:0] host_addr;
    logic [3:0] host_wdata;
    logic [3:0] host_rdata;
    logic       busy;
    logic       done;
    logic       rd_valid;
    logic [4:0] rd_addr;
    logic [3:0] rd_data;

    always #5 clk = ~clk;

    bram_sweep #(
        .DATA_W(4),
        .ADDR_W(5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .len       (len),
        .seed      (seed),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .busy      (busy),
        .done      (done),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    int         checks   = 0;
    int         failures = 0;
    int         beats    = 0;
    logic [3:0] model [32];
    logic [8:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_host_rdata"}, host_rdata, 0);
    endtask

    task automatic host_read(input logic [4:0] a);
        host_addr = a;
        step();
        chk("host_rd", host_rdata, model[a]);
    endtask

    // Read beats are checked against expectations pushed when the sweep starts.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_valid === 1'b1) begin
            logic [8:0] e;
            beats++;
            chk("rd_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rd_addr", rd_addr, e[8:4]);
                chk("rd_data", rd_data, e[3:0]);
            end
        end
    end

    task automatic run_sweep(input logic m, input logic [4:0] base, input logic [5:0] n,
                             input logic [3:0] sd, input logic poke, input string tag);
        int         cyc;
        int         exp_done;
        int         beats0;
        logic [4:0] a;
        exp_done = (m == 1'b1) ? int'(n) + 1 : int'(n) + 2;
        for (int i = 0; i < int'(n); i++) begin
            a = base + 5'(i);
            if (m == 1'b1) model[a] = sd + 4'(i);
            else exp_q.push_back({a, model[a]});
        end
        beats0    = beats;
        start     = 1'b1;
        mode      = m;
        base_addr = base;
        len       = n;
        seed      = sd;
        step();
        start = 1'b0;
        cyc   = 1;
        chk({tag, "_busy"}, busy, 1);
        while (done !== 1'b1 && cyc < 100) begin
            if (poke && cyc == 2) begin
                start      = 1'b1;
                mode       = 1'b1;
                len        = 6'd3;
                host_we    = 1'b1;
                host_addr  = 5'd20;
                host_wdata = 4'hF;
            end
            step();
            cyc++;
            if (poke && cyc == 3) begin
                start   = 1'b0;
                host_we = 1'b0;
            end
        end
        chk({tag, "_done_cyc"}, cyc, exp_done);
        chk({tag, "_idle_at_done"}, busy, 0);
        step();
        chk({tag, "_done_pulse"}, done, 0);
        if (m == 1'b0) chk({tag, "_beats"}, beats - beats0, int'(n));
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        base_addr  = '0;
        len        = '0;
        seed       = '0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        step();
        step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        // Full fill then full scan: every word equals its low address bits.
        run_sweep(1'b1, 5'd0, 6'd32, 4'd0, 1'b0, "fill_all");
        run_sweep(1'b0, 5'd0, 6'd32, 4'd0, 1'b0, "read_all");

        // Window wrapping past the top address.
        run_sweep(1'b1, 5'd30, 6'd4, 4'd9, 1'b0, "fill_wrap");
        run_sweep(1'b0, 5'd30, 6'd4, 4'd0, 1'b0, "read_wrap");

        // Host write, then read-before-write on the same address.
        host_addr  = 5'd5;
        host_wdata = 4'hE;
        host_we    = 1'b1;
        step();
        host_we  = 1'b0;
        model[5] = 4'hE;
        host_read(5'd5);
        host_addr  = 5'd7;
        host_wdata = 4'h3;
        host_we    = 1'b1;
        step();
        host_we = 1'b0;
        chk("rbw_old", host_rdata, model[7]);
        model[7] = 4'h3;
        host_read(5'd7);

        // Zero-length start: immediate done, no busy, memory untouched.
        start = 1'b1;
        mode  = 1'b1;
        len   = 6'd0;
        seed  = 4'h5;
        step();
        start = 1'b0;
        chk("len0_busy", busy, 0);
        chk("len0_done", done, 1);
        step();
        chk("len0_done_clear", done, 0);
        chk("len0_busy2", busy, 0);
        host_read(5'd0);
        host_read(5'd31);

        // Start and host write during a read sweep are dropped.
        run_sweep(1'b0, 5'd8, 6'd6, 4'd0, 1'b1, "read_poke");
        for (int i = 0; i < 4; i++) begin
            step();
            chk("poke_no_sweep", busy, 0);
        end
        host_read(5'd20);

        // Abort a fill after five writes.
        host_read(5'd10);
        start     = 1'b1;
        mode      = 1'b1;
        base_addr = 5'd0;
        len       = 6'd20;
        seed      = 4'd0;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("hold_busy", host_rdata, model[10]);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) model[i] = 4'(i);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_done", done, 0);
        end
        for (int i = 0; i < 32; i++) host_read(5'(i));
        run_sweep(1'b0, 5'd28, 6'd8, 4'd0, 1'b0, "read_after_abort");

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
